// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the LSU (master)
// and the data-memory controller (slave).
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller: word RAM, byte-lane stores, load extension.
// Define DMEM_RANGE_CHECK_EN to fault accesses beyond the array.
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q;

  logic [31:0] mem [2**ADDR_W];

  logic              accept;
  logic              access;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic              bad_f3, misal, bad_st, oor, err_c;
  logic [3:0]        be;
  logic [31:0]       wdat;
  logic [31:0]       word;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  assign idx  = addr_q[ADDR_W+1:2];
  assign lane = addr_q[1:0];

  assign bus.req_ready = !rst &&
    (state_q == IDLE || state_q == RESP);
  assign accept = bus.req_valid && bus.req_ready;
  assign access = (state_q == BUSY) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = BUSY;
        cnt_d   = 4'(WAIT_STATES);
      end
      BUSY: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else state_d = RESP;
      RESP: if (accept) begin
        state_d = BUSY;
        cnt_d   = 4'(WAIT_STATES);
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (f3_q)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = addr_q[0];
      3'b010:         misal = |addr_q[1:0];
      default:        bad_f3 = 1'b1;
    endcase
  end

  assign bad_st = we_q & f3_q[2];

`ifdef DMEM_RANGE_CHECK_EN
  assign oor = |addr_q[31:ADDR_W+2];
`else
  // Upper bits alias onto the array.
  assign oor = 1'b0;
  logic unused_hi;
  assign unused_hi = ^addr_q[31:ADDR_W+2];
`endif

  assign err_c = bad_f3 | misal | bad_st | oor;

  always_comb begin
    be   = 4'b0000;
    wdat = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be   = 4'b0001 << lane;
        wdat = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wdat = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && access && we_q && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign word   = mem[idx];
  assign half_v = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    if (!we_q && !err_c) begin
      case (f3_q)
        3'b000:  rdata_d = {{24{byte_v[7]}}, byte_v};
        3'b100:  rdata_d = {24'd0, byte_v};
        3'b001:  rdata_d = {{16{half_v[15]}}, half_v};
        3'b101:  rdata_d = {16'd0, half_v};
        3'b010:  rdata_d = word;
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (access) begin
        rdata_q <= rdata_d;
        err_q   <= err_c;
      end
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
  assign bus.rsp_err   = (state_q == RESP) & err_q;

endmodule
